// File: rtl/dht11_pkg.sv
// Shared types, default timing constants and the frame checksum for the
// DHT11 sample scheduler.
package dht11_pkg;

  localparam int unsigned CLK_PER_US_DEF = 100;
  localparam int unsigned US_PER_MS_DEF  = 1000;
  localparam int unsigned PERIOD_MS_DEF  = 2000;
  localparam int unsigned TIMEOUT_MS_DEF = 30;
  localparam int unsigned MAX_RETRY_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_DONE = 3'd2,
    CHECK     = 3'd3,
    GAP       = 3'd4
  } state_t;

  // DHT11 checksum is the byte sum of the four data bytes, wrapping at 8 bits.
  function automatic logic [7:0] dht11_crc(input logic [15:0] hmd, input logic [15:0] tmp);
    return hmd[15:8] + hmd[7:0] + tmp[15:8] + tmp[7:0];
  endfunction

endpackage

// File: rtl/dht11_ms_tick.sv
// Two-stage down-counter divider producing a one-cycle millisecond tick;
// clr restarts the divider so the first tick lands a full ms after it.
module dht11_ms_tick #(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned US_PER_MS  = 1000
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  output logic tick
);

  localparam int unsigned UW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned MW = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;

  logic [UW-1:0] us_cnt;
  logic [MW-1:0] ms_cnt;
  logic          us_tc;

  assign us_tc = (us_cnt == '0);
  assign tick  = us_tc && (ms_cnt == '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      us_cnt <= '0;
      ms_cnt <= '0;
    end else if (clr) begin
      us_cnt <= UW'(CLK_PER_US - 1);
      ms_cnt <= MW'(US_PER_MS - 1);
    end else begin
      us_cnt <= us_tc ? UW'(CLK_PER_US - 1) : us_cnt - 1'b1;
      if (us_tc) begin
        ms_cnt <= (ms_cnt == '0) ? MW'(US_PER_MS - 1) : ms_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dht11_sample_scheduler.sv
// Paces DHT11 start triggers, validates each frame checksum, keeps the last
// good reading and tracks timeouts, checksum errors and bounded retries.
//
// state     | meaning
// IDLE      | nothing to do until en or a pending request
// TRIG      | one-cycle start_trig, restart ms timers
// WAIT_DONE | wait for done from the controller or the timeout
// CHECK     | compare captured checksum, update outputs or count failure
// GAP       | hold off until PERIOD_MS since the last start_trig
module dht11_sample_scheduler
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US = CLK_PER_US_DEF,
  parameter int unsigned US_PER_MS  = US_PER_MS_DEF,
  parameter int unsigned PERIOD_MS  = PERIOD_MS_DEF,
  parameter int unsigned TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        en,
  input  logic        req,
  output logic        start_trig,
  input  logic        done,
  input  logic [15:0] hmd,
  input  logic [15:0] tmp,
  input  logic [7:0]  sum,
  output logic [15:0] hmd_o,
  output logic [15:0] tmp_o,
  output logic        valid,
  output logic        new_pulse,
  output logic        err_crc,
  output logic        err_tmo,
  output logic [7:0]  crc_err_cnt,
  output logic [7:0]  tmo_cnt,
  output logic        busy,
  output logic        fail
);

  localparam int unsigned TW = $clog2(TIMEOUT_MS + 1);
  localparam int unsigned PW = $clog2(PERIOD_MS + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t        state, state_nxt;
  logic          tick, trig, capture, good, bad_crc, tmo, fail_evt;
  logic          pend, retry_pend;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] tmo_left;
  logic [PW-1:0] per_left;
  logic [15:0]   cap_hmd, cap_tmp;
  logic [7:0]    cap_sum;

  dht11_ms_tick #(
    .CLK_PER_US(CLK_PER_US),
    .US_PER_MS (US_PER_MS)
  ) u_ms_tick (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .clr    (trig),
    .tick   (tick)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // done is tested before the timeout so a coincident done is accepted.
  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    capture   = 1'b0;
    good      = 1'b0;
    bad_crc   = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (en || pend) state_nxt = TRIG;
      TRIG: begin
        trig      = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          capture   = 1'b1;
          state_nxt = CHECK;
        end else if (tmo_left == '0) begin
          tmo       = 1'b1;
          state_nxt = GAP;
        end
      end
      CHECK: begin
        if (cap_sum == dht11_crc(cap_hmd, cap_tmp)) good = 1'b1;
        else                                         bad_crc = 1'b1;
        state_nxt = GAP;
      end
      GAP: if (per_left == '0) state_nxt = (retry_pend || en || pend) ? TRIG : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start_trig = (state == TRIG);
  assign busy       = (state != IDLE);
  assign fail_evt   = bad_crc | tmo;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_left <= '0;
      per_left <= '0;
    end else if (trig) begin
      tmo_left <= TW'(TIMEOUT_MS);
      per_left <= PW'(PERIOD_MS);
    end else if (tick) begin
      if (tmo_left != '0) tmo_left <= tmo_left - 1'b1;
      if (per_left != '0) per_left <= per_left - 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pend       <= 1'b0;
      retry_pend <= 1'b0;
      retry_cnt  <= '0;
      fail       <= 1'b0;
      cap_hmd    <= '0;
      cap_tmp    <= '0;
      cap_sum    <= '0;
    end else begin
      pend <= req | (pend & ~trig);
      if (trig) retry_pend <= 1'b0;
      if (capture) begin
        cap_hmd <= hmd;
        cap_tmp <= tmp;
        cap_sum <= sum;
      end
      if (good) begin
        retry_cnt <= '0;
        fail      <= 1'b0;
      end else if (fail_evt) begin
        if (retry_cnt < RW'(MAX_RETRY)) begin
          retry_cnt  <= retry_cnt + 1'b1;
          retry_pend <= 1'b1;
        end else begin
          retry_cnt <= '0;
          fail      <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      hmd_o       <= '0;
      tmp_o       <= '0;
      valid       <= 1'b0;
      new_pulse   <= 1'b0;
      err_crc     <= 1'b0;
      err_tmo     <= 1'b0;
      crc_err_cnt <= '0;
      tmo_cnt     <= '0;
    end else begin
      new_pulse <= good;
      err_crc   <= bad_crc;
      err_tmo   <= tmo;
      if (good) begin
        hmd_o <= cap_hmd;
        tmp_o <= cap_tmp;
        valid <= 1'b1;
      end
      if (bad_crc && crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;
      if (tmo && tmo_cnt != 8'hFF)         tmo_cnt     <= tmo_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dht11_sample_scheduler.sv
// Self-checking bench: table of triggered frames with a scoreboard of expected
// output events, plus hand sequences for timeout, request collapse, saturation and reset.
module tb_dht11_sample_scheduler;

  localparam int CPU        = 2;
  localparam int UPM        = 4;
  localparam int PER        = 10;
  localparam int TMO        = 3;
  localparam int MR         = 2;
  localparam int CYC_PER_MS = CPU * UPM;

  logic        PCLK = 1'b0, PRESETn = 1'b0, en = 1'b0, req = 1'b0, done = 1'b0;
  logic [15:0] hmd = '0, tmp = '0;
  logic [7:0]  sum = '0;
  logic        start_trig, valid, new_pulse, err_crc, err_tmo, busy, fail;
  logic [15:0] hmd_o, tmp_o;
  logic [7:0]  crc_err_cnt, tmo_cnt;

  dht11_sample_scheduler #(
    .CLK_PER_US(CPU), .US_PER_MS(UPM), .PERIOD_MS(PER), .TIMEOUT_MS(TMO), .MAX_RETRY(MR)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .req(req), .start_trig(start_trig),
    .done(done), .hmd(hmd), .tmp(tmp), .sum(sum), .hmd_o(hmd_o), .tmp_o(tmp_o),
    .valid(valid), .new_pulse(new_pulse), .err_crc(err_crc), .err_tmo(err_tmo),
    .crc_err_cnt(crc_err_cnt), .tmo_cnt(tmo_cnt), .busy(busy), .fail(fail)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int trig_total = 0;
  always @(negedge PCLK) if (start_trig) trig_total++;

  typedef struct {
    logic [2:0]  kind;   // {new_pulse, err_crc, err_tmo}
    logic [15:0] h, t;
    logic [7:0]  crc, tmo;
    logic        fl, vl;
    int          at;
  } exp_t;

  typedef struct {
    bit          kick;   // 1: req from IDLE, 0: retry trigger expected
    bit          resp;   // 1: answer with done, 0: let it time out
    logic [15:0] h, t;
    logic [7:0]  s;
    bit          good;
  } vec_t;

  exp_t sb[$];
  bit   mon_on = 1'b1;

  logic [15:0] m_h = '0, m_t = '0;
  logic [7:0]  m_crc = '0, m_tmo = '0;
  logic        m_fail = 1'b0, m_valid = 1'b0;
  int          m_retry = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  task automatic model_apply(input logic [2:0] kind, input logic [15:0] h, input logic [15:0] t);
    if (kind == 3'b100) begin
      m_h = h; m_t = t; m_valid = 1'b1; m_fail = 1'b0; m_retry = 0;
    end else begin
      if (kind == 3'b010) m_crc = (m_crc == 8'hFF) ? m_crc : 8'(m_crc + 1);
      else                m_tmo = (m_tmo == 8'hFF) ? m_tmo : 8'(m_tmo + 1);
      if (m_retry < MR) m_retry++;
      else begin
        m_fail = 1'b1; m_retry = 0;
      end
    end
  endtask

  task automatic push_evt(input logic [2:0] kind, input logic [15:0] h, input logic [15:0] t, input int at);
    exp_t e;
    model_apply(kind, h, t);
    e = '{kind, m_h, m_t, m_crc, m_tmo, m_fail, m_valid, at};
    sb.push_back(e);
  endtask

  always @(negedge PCLK) begin
    exp_t e;
    if (mon_on && (new_pulse || err_crc || err_tmo)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event actual=%b required=000", {new_pulse, err_crc, err_tmo});
      end else begin
        e = sb.pop_front();
        chk("event_kind", {29'd0, new_pulse, err_crc, err_tmo}, {29'd0, e.kind});
        chk("event_cycle", cyc, e.at);
        chk("hmd_o", hmd_o, e.h);
        chk("tmp_o", tmp_o, e.t);
        chk("crc_err_cnt", crc_err_cnt, e.crc);
        chk("tmo_cnt", tmo_cnt, e.tmo);
        chk("fail", fail, e.fl);
        chk("valid", valid, e.vl);
      end
    end
  end

  task automatic wait_idle(input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge PCLK);
      if (!busy) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle actual=busy required=idle within %0d cycles", max);
  endtask

  task automatic wait_trig(input int max, output int tc, output bit ok);
    for (int n = 0; n < max; n++) begin
      @(negedge PCLK);
      if (start_trig) begin
        tc = cyc; ok = 1'b1;
        return;
      end
    end
    tc = cyc; ok = 1'b0;
    checks++; errors++;
    $display("FAIL wait_trig actual=none required=start_trig within %0d cycles", max);
  endtask

  task automatic wait_sb(input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge PCLK);
      if (sb.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    sb.delete();
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge of the TRIG cycle.
  task automatic kick(output int tc);
    req = 1'b1;
    @(negedge PCLK);
    req = 1'b0;
    chk("trig_latency_1", start_trig, 1'b0);
    @(negedge PCLK);
    chk("trig_latency_2", start_trig, 1'b1);
    tc = cyc;
  endtask

  task automatic respond(input logic [15:0] h, input logic [15:0] t, input logic [7:0] s, input bit good);
    hmd = h; tmp = t; sum = s; done = 1'b1;
    if (mon_on) push_evt(good ? 3'b100 : 3'b010, h, t, cyc + 2);
    else        model_apply(good ? 3'b100 : 3'b010, h, t);
    @(negedge PCLK);
    done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];

  initial begin
    int  tc, last_trig, t0, tc2;
    bit  ok, seen;

    tbl[0] = '{1'b1, 1'b1, 16'h3700, 16'h1A00, 8'h51, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 16'hFF01, 16'h0102, 8'h03, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 16'hFF01, 16'h0102, 8'h04, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h1234, 16'h5678, 8'h14, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 8'h01, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 16'h2A05, 16'h1907, 8'h4F, 1'b1};

    repeat (3) @(negedge PCLK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_start_trig", start_trig, 1'b0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst_hmd_o", hmd_o, 16'h0);
    chk("rst_counts", {crc_err_cnt, tmo_cnt}, 16'h0);
    chk("rst_fail", fail, 1'b0);

    last_trig = 0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].kick) begin
        wait_idle(300);
        kick(tc);
      end else begin
        wait_trig(120, tc, ok);
        chk("retry_gap_ok", ((tc - last_trig) >= PER * CYC_PER_MS) ? 1 : 0, 1);
      end
      last_trig = tc;
      if (tbl[i].resp) begin
        repeat (3) @(negedge PCLK);
        respond(tbl[i].h, tbl[i].t, tbl[i].s, tbl[i].good);
      end else begin
        push_evt(3'b001, 16'h0, 16'h0, tc + 1 + TMO * CYC_PER_MS + 1);
      end
      wait_sb(60);
    end

    // done coincides with the timeout cycle: done must win
    wait_idle(300);
    kick(tc);
    repeat (1 + TMO * CYC_PER_MS) @(negedge PCLK);
    respond(16'h4000, 16'h1500, 8'h55, 1'b1);
    wait_sb(10);
    chk("boundary_tmo_cnt", tmo_cnt, m_tmo);

    // en held for one trigger then dropped: retries still run, then fail
    wait_idle(300);
    mon_on = 1'b0;
    t0 = trig_total;
    en = 1'b1;
    wait_trig(10, tc, ok);
    en = 1'b0;
    for (int k = 0; k < 3; k++) model_apply(3'b001, 16'h0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      wait_trig(120, tc2, ok);
      chk("tmo_retry_spacing", ((tc2 - tc) >= PER * CYC_PER_MS) ? 1 : 0, 1);
      tc = tc2;
    end
    repeat (250) @(negedge PCLK);
    chk("tmo_trig_count", trig_total - t0, 3);
    chk("tmo_cnt_after3", tmo_cnt, m_tmo);
    chk("fail_set", fail, 1'b1);
    mon_on = 1'b1;
    wait_idle(300);
    kick(tc);
    repeat (2) @(negedge PCLK);
    respond(16'h3700, 16'h1A00, 8'h51, 1'b1);
    wait_sb(10);
    chk("fail_cleared", fail, 1'b0);

    // three requests during GAP collapse into one trigger
    wait_idle(300);
    kick(tc);
    repeat (2) @(negedge PCLK);
    respond(16'h1111, 16'h2222, 8'h66, 1'b1);
    t0 = trig_total;
    for (int k = 0; k < 3; k++) begin
      repeat (8) @(negedge PCLK);
      req = 1'b1;
      @(negedge PCLK);
      req = 1'b0;
    end
    wait_trig(120, tc2, ok);
    chk("req_gap_spacing", ((tc2 - tc) >= PER * CYC_PER_MS) ? 1 : 0, 1);
    repeat (2) @(negedge PCLK);
    respond(16'h2000, 16'h1000, 8'h30, 1'b1);
    wait_sb(10);
    repeat (200) @(negedge PCLK);
    chk("req_collapse_trigs", trig_total - t0, 1);

    // 300 forced checksum failures: counter saturates
    wait_idle(300);
    mon_on = 1'b0;
    en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      wait_trig(120, tc, ok);
      if (!ok) break;
      repeat (2) @(negedge PCLK);
      respond(16'h1111, 16'h2222, 8'h00, 1'b0);
    end
    en = 1'b0;
    repeat (4) @(negedge PCLK);
    chk("crc_saturate", crc_err_cnt, m_crc);
    chk("crc_sat_fail", fail, m_fail);
    mon_on = 1'b1;

    // reset pulse during WAIT_DONE
    wait_idle(300);
    kick(tc);
    repeat (2) @(negedge PCLK);
    chk("pre_rst_busy", busy, 1'b1);
    PRESETn = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_outs", {hmd_o, tmp_o}, 32'h0);
    chk("async_rst_cnts", {crc_err_cnt, tmo_cnt, 5'd0, valid, fail, new_pulse}, 24'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    m_h = '0; m_t = '0; m_crc = '0; m_tmo = '0; m_fail = 1'b0; m_valid = 1'b0; m_retry = 0;
    t0 = trig_total;
    hmd = 16'h3700; tmp = 16'h1A00; sum = 8'h51; done = 1'b1;
    @(negedge PCLK);
    done = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      if (new_pulse) seen = 1'b1;
    end
    chk("post_rst_done_ignored", seen, 1'b0);
    chk("post_rst_valid", valid, 1'b0);
    chk("post_rst_hmd_o", hmd_o, 16'h0);
    repeat (100) @(negedge PCLK);
    chk("post_rst_no_trig", trig_total - t0, 0);
    chk("post_rst_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dht11_sample_scheduler.md
DHT11_SAMPLE_SCHEDULER -- requirements
Module: dht11_sample_scheduler

Interface
REQ-001 Parameters SHALL be as follows.
- CLK_PER_US, 100: PCLK cycles per microsecond tick.
- US_PER_MS, 1000: microsecond ticks per millisecond tick.
- PERIOD_MS, 2000: minimum gap between any two start_trig pulses.
- TIMEOUT_MS, 30: maximum wait for done after start_trig.
- MAX_RETRY, 2: re-triggers allowed after a failed sample.
REQ-002 Ports SHALL be as follows.
- PCLK, input, 1: the single clock.
- PRESETn, input, 1: reset, asynchronous, active-low.
- en, input, 1: enables periodic sampling.
- req, input, 1: one-cycle request for a single sample.
- start_trig, output, 1: one-cycle pulse to the DHT11 controller.
- done, input, 1: one-cycle frame-complete pulse from the controller.
- hmd, input, 16: humidity integer/fraction bytes from the controller.
- tmp, input, 16: temperature integer/fraction bytes from the controller.
- sum, input, 8: checksum byte from the controller.
- hmd_o, output, 16: last good humidity.
- tmp_o, output, 16: last good temperature.
- valid, output, 1: at least one good sample since reset.
- new_pulse, output, 1: one cycle when hmd_o/tmp_o update.
- err_crc, output, 1: one-cycle checksum-failure pulse.
- err_tmo, output, 1: one-cycle timeout pulse.
- crc_err_cnt, output, 8: saturating checksum-failure count.
- tmo_cnt, output, 8: saturating timeout count.
- busy, output, 1: high in any state except IDLE.
- fail, output, 1: retries exhausted; sticky until the next good sample.

Function
REQ-003 The FSM states SHALL be IDLE, TRIG, WAIT_DONE, CHECK, GAP.
REQ-004 IDLE: if en=1 or a request is pending, the FSM SHALL go to TRIG; otherwise it SHALL stay in IDLE.
REQ-005 TRIG SHALL assert start_trig for exactly one cycle, clear the ms counter, and go to WAIT_DONE.
REQ-006 WAIT_DONE: on done=1, hmd/tmp/sum SHALL be captured in that same cycle and the FSM SHALL go to CHECK.
REQ-007 WAIT_DONE: a timeout SHALL occur when the ms count reaches TIMEOUT_MS. On timeout the block SHALL pulse err_tmo, increment tmo_cnt, count a failure, and go to GAP.
REQ-008 If done and the timeout condition occur in the same cycle, done SHALL win.
REQ-009 CHECK SHALL compare sum against (hmd[15:8]+hmd[7:0]+tmp[15:8]+tmp[7:0]) mod 256, using 8-bit wrap-around arithmetic.
REQ-010 On a checksum match, hmd_o and tmp_o SHALL load on the next edge, together with new_pulse=1, valid=1, fail=0 and retry count=0.
REQ-011 On a checksum mismatch, the block SHALL pulse err_crc, increment crc_err_cnt, and count a failure; hmd_o and tmp_o SHALL stay unchanged.
REQ-012 On a failure with retry count < MAX_RETRY, the retry count SHALL increment and the FSM SHALL go to GAP, marked to re-trigger.
REQ-013 On a failure with retry count = MAX_RETRY, fail SHALL be set to 1 and the retry count cleared.
REQ-014 GAP SHALL wait until PERIOD_MS ms have elapsed since the last start_trig.
- It SHALL then go to TRIG if a retry is pending, en=1, or a request is pending.
- Otherwise it SHALL go to IDLE.
REQ-015 A req pulse arriving in any state SHALL set a single pending flag. The flag SHALL clear on the next start_trig; multiple requests SHALL collapse into one.
REQ-016 Dropping en mid-transaction SHALL NOT abort it. The current sample and any pending retries SHALL complete, and GAP SHALL still be honoured.
REQ-017 crc_err_cnt and tmo_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-018 done asserted outside WAIT_DONE SHALL be ignored.
REQ-019 Latency: start_trig SHALL assert 2 cycles after a req in IDLE (one cycle to latch, one for TRIG). new_pulse SHALL assert 2 cycles after done.

Reset
REQ-020 On PRESETn=0, the FSM SHALL enter IDLE immediately (asynchronously), and every output, counter, pending flag and tick divider SHALL clear to 0.
REQ-021 After PRESETn is released, the first trigger SHALL NOT wait PERIOD_MS.

Structure
REQ-022 Package dht11_pkg SHALL hold the state enum and the checksum function; it SHALL also hold the timing constants used as parameter defaults.
REQ-023 Sub-module dht11_ms_tick SHALL be instantiated, producing a one-cycle ms tick from the CLK_PER_US and US_PER_MS parameters.

Verification
(All scenarios use CLK_PER_US=2, US_PER_MS=4, PERIOD_MS=10, TIMEOUT_MS=3, MAX_RETRY=2.)
REQ-024 Good sample: req pulse, then done with hmd=0x3700, tmp=0x1A00, sum=0x51 -> hmd_o=0x3700, tmp_o=0x1A00, valid=1, one new_pulse.
REQ-025 Checksum wrap: hmd=0xFF01, tmp=0x0102, sum=0x03 -> accepted. The same frame with sum=0x04 -> err_crc, crc_err_cnt=1, outputs unchanged.
REQ-026 No done, en=1 -> exactly 3 start_trig pulses at least 10 ms apart, tmo_cnt=3, fail=1. A following good sample -> fail=0.
REQ-027 done in the same cycle as the 3 ms timeout -> sample accepted; tmo_cnt unchanged.
REQ-028 Three req pulses in GAP -> exactly one start_trig after GAP expires. Drive 300 forced CRC failures -> crc_err_cnt holds at 255.
REQ-029 PRESETn low for one cycle during WAIT_DONE -> all outputs 0, FSM in IDLE; a later done is ignored.
